// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Accepts a signed value plus a 3-bit note code over a valid/ready
//   handshake, converts the magnitude to BCD with a sequential
//   double-dabble engine (saturating to dashes when the magnitude needs
//   more than DEC_DIGITS digits), and time-multiplexes an N_DIGITS
//   common-anode 7-segment display with a per-digit dwell of DWELL_CNT
//   clocks.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   num_in     signed two's-complement value (NUM_W bits)
//   note_in    note code (3 bits)
//   num_valid  num_in/note_in valid
//   num_ready  block can accept a new value (IDLE only)
//   upd_done   one-cycle pulse when the display buffer has been written
//   an         digit enables, active-low, one-hot-low; an[N_DIGITS-1] is leftmost
//   seg        segments {a,b,c,d,e,f,g,dp}, active-low
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zero magnitude digits are blanked
//                    and the sign dash moves next to the first shown digit.

module seg_display_scan #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned NUM_W      = 10,
    parameter int unsigned DEC_DIGITS = 3,
    parameter int unsigned DWELL_CNT  = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_W-1:0]    num_in,
    input  logic [2:0]          note_in,
    input  logic                num_valid,
    output logic                num_ready,
    output logic                upd_done,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          seg
);

    localparam int unsigned BCD_W   = 4 * DEC_DIGITS;
    localparam int unsigned CNT_W   = $clog2(DWELL_CNT);
    localparam int unsigned IDX_W   = $clog2(N_DIGITS);
    localparam int unsigned STEP_W  = $clog2(NUM_W);
    localparam int unsigned MAX_MAG = 10**DEC_DIGITS - 1;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hFD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABS,
        S_CONV,
        S_COMMIT
    } state_t;

    // Conversion state
    state_t              state_q, state_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [2:0]          note_q, note_d;
    logic                sign_q, sign_d;
    logic                sat_q, sat_d;
    logic [NUM_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                num_ready_q, num_ready_d;
    logic                upd_done_q, upd_done_d;

    // Display buffer and scan state
    logic [7:0]          buf_q [N_DIGITS];
    logic [7:0]          buf_d [N_DIGITS];
    logic [7:0]          buf_new [N_DIGITS];
    logic                buf_we;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    // Helpers
    logic [NUM_W-1:0]    abs_mag;
    logic [BCD_W-1:0]    bcd_adj;
    int unsigned         lz_cnt;
`ifdef SEG_LZ_BLANK_EN
    logic                lz_seen;
`endif

    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'd0:    g = 8'h03;
            4'd1:    g = 8'hF3;
            4'd2:    g = 8'h25;
            4'd3:    g = 8'h0D;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h49;
            4'd6:    g = 8'h41;
            4'd7:    g = 8'h1F;
            4'd8:    g = 8'h01;
            4'd9:    g = 8'h09;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // k = 0 is the most significant magnitude digit
    function automatic logic [3:0] mag_digit(input logic [BCD_W-1:0] bcd, input int unsigned k);
        return bcd[4*(DEC_DIGITS-1-k) +: 4];
    endfunction

    // |num_q| as NUM_W-bit unsigned; the most negative value maps exactly
    always_comb begin
        abs_mag = num_q[NUM_W-1] ? (~num_q + NUM_W'(1)) : num_q;
    end

    // Double-dabble correction applied before every shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DEC_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next state
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        note_d     = note_q;
        sign_d     = sign_q;
        sat_d      = sat_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        upd_done_d = 1'b0;
        buf_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (num_valid && num_ready_q) begin
                    num_d   = num_in;
                    note_d  = note_in;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                sign_d  = num_q[NUM_W-1];
                bin_d   = abs_mag;
                sat_d   = (32'(abs_mag) > MAX_MAG);
                bcd_d   = '0;
                step_d  = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                // BCD register only holds DEC_DIGITS digits; any overflow
                // is covered by sat_q, so truncated upper bits are harmless.
                bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[NUM_W-1]};
                bin_d  = {bin_q[NUM_W-2:0], 1'b0};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(NUM_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                buf_we     = 1'b1;
                upd_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        num_ready_d = (state_d == S_IDLE);
    end

    // New buffer image built from the finished conversion
    always_comb begin
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            buf_new[d] = GLYPH_BLANK;
        end

        lz_cnt = 0;
`ifdef SEG_LZ_BLANK_EN
        lz_seen = 1'b0;
        if (!sat_q) begin
            // The units digit is never blanked, so only the upper digits count
            for (int unsigned k = 0; k + 1 < DEC_DIGITS; k++) begin
                if (!lz_seen && (mag_digit(bcd_q, k) == 4'd0)) begin
                    lz_cnt = lz_cnt + 1;
                end else begin
                    lz_seen = 1'b1;
                end
            end
        end
`endif

        for (int unsigned k = 0; k < DEC_DIGITS; k++) begin
            if (sat_q) begin
                buf_new[IDX_W'(k + 1)] = GLYPH_DASH;
            end else if (k >= lz_cnt) begin
                buf_new[IDX_W'(k + 1)] = glyph(mag_digit(bcd_q, k));
            end
        end

        // The sign sits just left of the first shown magnitude digit
        if (sign_q) begin
            buf_new[IDX_W'(lz_cnt)] = GLYPH_DASH;
        end

        case (note_q)
            3'd0, 3'd5: buf_new[IDX_W'(N_DIGITS - 1)] = 8'h61;
            3'd1:       buf_new[IDX_W'(N_DIGITS - 1)] = 8'h11;
            3'd2:       buf_new[IDX_W'(N_DIGITS - 1)] = 8'h85;
            3'd3: begin
                buf_new[IDX_W'(N_DIGITS - 3)] = 8'h49;
                buf_new[IDX_W'(N_DIGITS - 2)] = 8'h03;
                buf_new[IDX_W'(N_DIGITS - 1)] = 8'hE3;
            end
            3'd4:       buf_new[IDX_W'(N_DIGITS - 1)] = 8'hC1;
            default: ;
        endcase

        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            buf_d[d] = buf_we ? buf_new[d] : buf_q[d];
        end
    end

    // Scan next state; seg reads buf_q so a commit shows up one cycle later
    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == CNT_W'(DWELL_CNT - 1)) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
        end
        an_d  = ~(N_DIGITS'(1) << (IDX_W'(N_DIGITS - 1) - dig_idx_q));
        seg_d = buf_q[dig_idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            note_q      <= '0;
            sign_q      <= 1'b0;
            sat_q       <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            num_ready_q <= 1'b0;
            upd_done_q  <= 1'b0;
            for (int unsigned d = 0; d < N_DIGITS; d++) begin
                buf_q[d] <= GLYPH_BLANK;
            end
            scan_cnt_q  <= '0;
            dig_idx_q   <= '0;
            an_q        <= '1;
            seg_q       <= '1;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            note_q      <= note_d;
            sign_q      <= sign_d;
            sat_q       <= sat_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            step_q      <= step_d;
            num_ready_q <= num_ready_d;
            upd_done_q  <= upd_done_d;
            buf_q       <= buf_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign num_ready = num_ready_q;
    assign upd_done  = upd_done_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
//   Directed bench for seg_display_scan. Three instances share clk/rst_n:
//     u_dut  : default parameters (dwell 2000)
//     u_fast : NUM_W=10, dwell 2 (quick buffer read-back)
//     u_w12  : NUM_W=12, dwell 2 (saturation cases)
//   Buffer contents are read back through the scanned an/seg pins.

module tb_seg_display_scan;

    logic clk;
    logic rst_n;

    logic [9:0]  d_num;  logic [2:0] d_note; logic d_valid, d_ready, d_done;
    logic [7:0]  d_an, d_seg;
    logic [9:0]  f_num;  logic [2:0] f_note; logic f_valid, f_ready, f_done;
    logic [7:0]  f_an, f_seg;
    logic [11:0] w_num;  logic [2:0] w_note; logic w_valid, w_ready, w_done;
    logic [7:0]  w_an, w_seg;

    int n_vec;
    int n_err;
    logic [7:0] rd [8];

`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg_display_scan u_dut (
        .clk(clk), .rst_n(rst_n), .num_in(d_num), .note_in(d_note),
        .num_valid(d_valid), .num_ready(d_ready), .upd_done(d_done),
        .an(d_an), .seg(d_seg)
    );

    seg_display_scan #(.N_DIGITS(8), .NUM_W(10), .DEC_DIGITS(3), .DWELL_CNT(2)) u_fast (
        .clk(clk), .rst_n(rst_n), .num_in(f_num), .note_in(f_note),
        .num_valid(f_valid), .num_ready(f_ready), .upd_done(f_done),
        .an(f_an), .seg(f_seg)
    );

    seg_display_scan #(.N_DIGITS(8), .NUM_W(12), .DEC_DIGITS(3), .DWELL_CNT(2)) u_w12 (
        .clk(clk), .rst_n(rst_n), .num_in(w_num), .note_in(w_note),
        .num_valid(w_valid), .num_ready(w_ready), .upd_done(w_done),
        .an(w_an), .seg(w_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cur_an(input int which);
        return (which == 0) ? d_an : (which == 1) ? f_an : w_an;
    endfunction

    function automatic logic [7:0] cur_seg(input int which);
        return (which == 0) ? d_seg : (which == 1) ? f_seg : w_seg;
    endfunction

    function automatic logic cur_done(input int which);
        return (which == 0) ? d_done : (which == 1) ? f_done : w_done;
    endfunction

    function automatic logic cur_ready(input int which);
        return (which == 0) ? d_ready : (which == 1) ? f_ready : w_ready;
    endfunction

    task automatic drive(input int which, input logic [11:0] num, input logic [2:0] note, input logic v);
        case (which)
            0:       begin d_num = num[9:0]; d_note = note; d_valid = v; end
            1:       begin f_num = num[9:0]; f_note = note; f_valid = v; end
            default: begin w_num = num;      w_note = note; w_valid = v; end
        endcase
    endtask

    // One-cycle valid pulse at a negedge; lat = edges from acceptance to upd_done
    task automatic send(input int which, input logic [11:0] num, input logic [2:0] note, output int lat);
        drive(which, num, note, 1'b1);
        @(negedge clk);
        drive(which, num, note, 1'b0);
        lat = 0;
        while (!cur_done(which) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Capture the glyph of every digit from the scanned outputs
    task automatic read_buf(input int which);
        for (int d = 0; d < 8; d++) begin
            logic [7:0] want;
            int t;
            want = ~(8'h80 >> d);
            t = 0;
            while (cur_an(which) !== want && t < 20000) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("rd_an[%0d]", d), cur_an(which), want);
            rd[d] = cur_seg(which);
        end
    endtask

    task automatic chk_buf(input string tag, input int which, input logic [63:0] exp);
        @(negedge clk);
        read_buf(which);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("%s[%0d]", tag, d), rd[d], exp[63-8*d -: 8]);
        end
    endtask

    initial begin
        int lat, cnt, bad_an, bad_seg, bad_rdy;
        logic [7:0] exp_an;
        bit seen_hi;

        n_vec = 0;
        n_err = 0;
        drive(0, '0, '0, 1'b0);
        drive(1, '0, '0, 1'b0);
        drive(2, '0, '0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_an",    d_an,    8'hFF);
        chk("rst_seg",   d_seg,   8'hFF);
        chk("rst_ready", d_ready, 1'b0);
        chk("rst_done",  d_done,  1'b0);

        // Idle scan over one full frame plus the wrap
        rst_n = 1'b1;
        bad_an = 0; bad_seg = 0; bad_rdy = 0;
        for (int k = 1; k <= 16001; k++) begin
            @(negedge clk);
            exp_an = ~(8'h80 >> (((k - 1) / 2000) % 8));
            if ((k % 2000) == 1 || (k % 2000) == 0) begin
                chk($sformatf("scan_an@%0d", k), d_an, exp_an);
            end else if (d_an !== exp_an) begin
                bad_an++;
            end
            if (d_seg !== 8'hFF) bad_seg++;
            if (d_ready !== 1'b1) bad_rdy++;
        end
        chk("scan_an_mid",  bad_an,  0);
        chk("scan_seg_blk", bad_seg, 0);
        chk("scan_ready",   bad_rdy, 0);

        // -37, note 3 on default instance
        send(0, 12'hFDB, 3'd3, lat);
        chk("m37_lat", lat, 12);
        chk("m37_ready", d_ready, 1'b1);
        @(negedge clk);
        chk("m37_done_pulse", d_done, 1'b0);
        chk_buf("m37", 0, LZ ? 64'hFF_FD_0D_1F_FF_49_03_E3 : 64'hFD_03_0D_1F_FF_49_03_E3);

        // Most negative 10-bit value, note 1
        send(1, 12'hE00, 3'd1, lat);
        chk("m512_lat", lat, 12);
        chk_buf("m512", 1, 64'hFD_49_F3_25_FF_FF_FF_11);

        // Zero is positive; note 0
        send(1, 12'h000, 3'd0, lat);
        chk_buf("zero", 1, LZ ? 64'hFF_FF_FF_03_FF_FF_FF_61 : 64'hFF_03_03_03_FF_FF_FF_61);

        // Largest positive 10-bit value, note 2
        send(1, 12'h1FF, 3'd2, lat);
        chk_buf("p511", 1, 64'hFF_49_F3_F3_FF_FF_FF_85);

        // -5, note 7 (blank note field)
        send(1, 12'hFFB, 3'd7, lat);
        chk_buf("m5", 1, LZ ? 64'hFF_FF_FD_49_FF_FF_FF_FF : 64'hFD_03_03_49_FF_FF_FF_FF);

        // NUM_W=12: 1500 saturates; num_ready low for 14 cycles
        drive(2, 12'd1500, 3'd6, 1'b1);
        @(negedge clk);
        drive(2, 12'd1500, 3'd6, 1'b0);
        cnt = 0;
        while (w_ready == 1'b0 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("w1500_ready_low", cnt, 14);
        chk("w1500_done", w_done, 1'b1);
        chk_buf("w1500", 2, 64'hFF_FD_FD_FD_FF_FF_FF_FF);

        // Saturation boundary 999 / 1000
        send(2, 12'd999, 3'd4, lat);
        chk("w999_lat", lat, 14);
        chk_buf("w999", 2, 64'hFF_09_09_09_FF_FF_FF_C1);
        send(2, 12'd1000, 3'd0, lat);
        chk_buf("w1000", 2, 64'hFF_FD_FD_FD_FF_FF_FF_61);

        // Negative saturation keeps the sign at d=0
        send(2, 12'hC18, 3'd3, lat);
        chk_buf("wm1000", 2, 64'hFD_FD_FD_FD_FF_49_03_E3);
        send(2, 12'h800, 3'd5, lat);
        chk_buf("wm2048", 2, 64'hFD_FD_FD_FD_FF_FF_FF_61);

        // num_valid held high: 5 then 6, re-acceptance 13 edges later
        drive(1, 12'd5, 3'd5, 1'b1);
        @(negedge clk);
        chk("hold_first_acc", f_ready, 1'b0);
        drive(1, 12'd6, 3'd5, 1'b1);
        cnt = 0;
        seen_hi = 1'b0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (f_ready) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        chk("hold_reaccept", cnt, 13);
        drive(1, 12'd6, 3'd5, 1'b0);
        cnt = 0;
        while (!f_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_second_lat", cnt, 12);
        chk_buf("hold6", 1, LZ ? 64'hFF_FF_FF_41_FF_FF_FF_61 : 64'hFF_03_03_41_FF_FF_FF_61);

        // Pulse while busy is dropped
        drive(1, 12'd7, 3'd0, 1'b1);
        @(negedge clk);
        drive(1, 12'd7, 3'd0, 1'b0);
        repeat (4) @(negedge clk);
        drive(1, 12'd8, 3'd0, 1'b1);
        @(negedge clk);
        drive(1, 12'd8, 3'd0, 1'b0);
        cnt = 0;
        while (!f_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("busy_lat", cnt, 7);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (f_done) cnt++;
        end
        chk("busy_dropped", cnt, 0);
        chk_buf("busy7", 1, LZ ? 64'hFF_FF_FF_1F_FF_FF_FF_61 : 64'hFF_03_03_1F_FF_FF_FF_61);

        // Reset asserted mid-conversion
        drive(1, 12'd3, 3'd1, 1'b1);
        @(negedge clk);
        drive(1, 12'd3, 3'd1, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_an",    f_an,    8'hFF);
        chk("rstmid_seg",   f_seg,   8'hFF);
        chk("rstmid_ready", f_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (f_done) cnt++;
        end
        chk("rstmid_no_done", cnt, 0);
        chk_buf("rstmid", 1, 64'hFF_FF_FF_FF_FF_FF_FF_FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
